// File: rtl/uart_cmd_sequencer_if.sv
// Command channel from the UART frame sequencer to the SRAM engine.
// One valid/ready transfer per host frame.
interface uart_cmd_sequencer_if #(
  parameter int ADDR_W = 19
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_wdata;

  modport master (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    output cmd_ready
  );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Assembles 'R'/'W' host frames from UART bytes into SRAM commands.
// Guards against timeouts, bad opcodes and overrun.
module uart_cmd_sequencer #(
  parameter int ADDR_W        = 19,
  parameter int ADDR_BYTES    = 3,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_tick,
  input  logic                  rx_done_tick,
  input  logic [7:0]            rx_data,
  uart_cmd_sequencer_if.master  cmd,
  output logic                  err_opcode_tick,
  output logic                  err_timeout_tick,
  output logic                  overrun_tick
);
  localparam int TW = $clog2(TIMEOUT_TICKS);
  localparam int BW = $clog2(ADDR_BYTES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(ADDR_BYTES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] ISSUE = 2'd3;

  logic [1:0]        state;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [BW-1:0]     bcnt;
  logic [TW-1:0]     to_cnt;

  logic [ADDR_W-1:0] addr_next;
  logic              is_op;
  logic              to_fire;

  // Address shift, opcode match and timeout expiry; a byte beats the tick
  always_comb begin
    addr_next = {addr_q[ADDR_W-9:0], rx_data};
    is_op     = (rx_data == 8'h57) || (rx_data == 8'h52);
    to_fire   = s_tick && !rx_done_tick && (to_cnt == TO_LAST);
  end

  assign cmd.cmd_valid = (state == ISSUE);
  assign cmd.cmd_write = write_q;
  assign cmd.cmd_addr  = addr_q;
  assign cmd.cmd_wdata = wdata_q;

  // Frame FSM with inter-byte timeout and registered event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      write_q          <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      bcnt             <= '0;
      to_cnt           <= '0;
      err_opcode_tick  <= 1'b0;
      err_timeout_tick <= 1'b0;
      overrun_tick     <= 1'b0;
    end else begin
      err_opcode_tick  <= 1'b0;
      err_timeout_tick <= 1'b0;
      overrun_tick     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_done_tick) begin
            if (is_op) begin
              write_q <= (rx_data == 8'h57);
              addr_q  <= '0;
              bcnt    <= '0;
              to_cnt  <= '0;
              state   <= ADDR;
            end else begin
              err_opcode_tick <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (rx_done_tick) begin
            addr_q <= addr_next;
            bcnt   <= bcnt + BW'(1);
            to_cnt <= '0;
            if (bcnt == B_LAST) begin
              if (write_q) begin
                state <= DATA;
              end else begin
                wdata_q <= 8'h00;
                state   <= ISSUE;
              end
            end
          end else if (to_fire) begin
            err_timeout_tick <= 1'b1;
            state            <= IDLE;
          end else if (s_tick) begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        DATA: begin
          if (rx_done_tick) begin
            wdata_q <= rx_data;
            state   <= ISSUE;
          end else if (to_fire) begin
            err_timeout_tick <= 1'b1;
            state            <= IDLE;
          end else if (s_tick) begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ISSUE: begin
          if (rx_done_tick) overrun_tick <= 1'b1;
          if (cmd.cmd_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Randomized bench for uart_cmd_sequencer.
// Transaction-level model: expected command queue plus event counts.
module tb_uart_cmd_sequencer;
  localparam int AW = 19;
  localparam int AB = 3;
  localparam int TT = 640;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       err_opcode_tick;
  logic       err_timeout_tick;
  logic       overrun_tick;

  uart_cmd_sequencer_if #(.ADDR_W(AW)) cmd_if ();

  uart_cmd_sequencer #(
    .ADDR_W(AW),
    .ADDR_BYTES(AB),
    .TIMEOUT_TICKS(TT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_tick(s_tick),
    .rx_done_tick(rx_done_tick),
    .rx_data(rx_data),
    .cmd(cmd_if),
    .err_opcode_tick(err_opcode_tick),
    .err_timeout_tick(err_timeout_tick),
    .overrun_tick(overrun_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          w;
    longint      a;
    int          d;
    int          start;
    int          len;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_op = 0, n_to = 0, n_ov = 0;
  int e_op = 0, e_to = 0, e_ov = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts pulses and checks every command cycle
  initial begin
    bit pv;
    int st, len;
    pv = 0; st = 0; len = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (err_opcode_tick === 1'b1) n_op++;
        if (err_timeout_tick === 1'b1) n_to++;
        if (overrun_tick === 1'b1) n_ov++;
        if (cmd_if.cmd_valid === 1'b1) begin
          if (!pv) begin
            st = cyc;
            len = 0;
          end
          len++;
          if (q.size() == 0) begin
            chk("unexpected_cmd", cmd_if.cmd_valid, 0);
          end else begin
            chk("cmd_write", cmd_if.cmd_write, q[0].w);
            chk("cmd_addr", cmd_if.cmd_addr, q[0].a);
            chk("cmd_wdata", cmd_if.cmd_wdata, q[0].d);
            if (cmd_if.cmd_ready === 1'b1) begin
              chk("cmd_start", st, q[0].start);
              chk("cmd_len", len, q[0].len);
              void'(q.pop_front());
            end
          end
          pv = (cmd_if.cmd_ready !== 1'b1);
        end else begin
          if (pv) chk("valid_drop", cmd_if.cmd_valid, 1);
          pv = 0;
        end
      end
    end
  end

  task automatic drive(input bit rx, input logic [7:0] d, input bit st);
    rx_done_tick = rx;
    rx_data = d;
    s_tick = st;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    s_tick = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 8'h00, ($urandom_range(0, 3) == 0));
  endtask

  task automatic do_frame(input bit wr, input logic [7:0] a0,
                          input logic [7:0] a1, input logic [7:0] a2,
                          input logic [7:0] wd, input int hold,
                          input int ovr_pos, input logic [7:0] ovr_b,
                          input int slow_idx, input int gap);
    logic [7:0] ab[AB];
    exp_t e;
    longint a;
    ab[0] = a0; ab[1] = a1; ab[2] = a2;
    a = 0;
    for (int i = 0; i < AB; i++) a = a * 256 + longint'(ab[i]);
    e.w = wr;
    e.a = a % (longint'(1) << AW);
    e.d = wr ? int'(wd) : 0;
    e.len = hold + 1;
    cmd_if.cmd_ready = (hold == 0);
    drive(1'b1, wr ? 8'h57 : 8'h52, 1'b0);
    for (int i = 0; i < AB; i++) begin
      if (i == slow_idx) begin
        repeat (TT - 1) drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, ab[i], 1'b1);
      end else begin
        idle_gap(gap);
        drive(1'b1, ab[i], ($urandom_range(0, 3) == 0));
      end
    end
    if (wr) begin
      idle_gap(gap);
      drive(1'b1, wd, ($urandom_range(0, 3) == 0));
    end
    e.start = cyc;
    q.push_back(e);
    for (int i = 0; i <= hold; i++) begin
      cmd_if.cmd_ready = (i == hold);
      if (i == ovr_pos) begin
        e_ov++;
        drive(1'b1, ovr_b, 1'b0);
      end else begin
        drive(1'b0, 8'h00, ($urandom_range(0, 3) == 0));
      end
    end
    cmd_if.cmd_ready = 1'b0;
    chk("idle_after_hs", cmd_if.cmd_valid, 0);
  endtask

  task automatic chk_counts(input string tag);
    @(negedge clk);
    chk({tag, "_op"}, n_op, e_op);
    chk({tag, "_to"}, n_to, e_to);
    chk({tag, "_ov"}, n_ov, e_ov);
    chk({tag, "_q"}, q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, cmd_if.cmd_valid, 0);
    chk({tag, "_write"}, cmd_if.cmd_write, 0);
    chk({tag, "_addr"}, cmd_if.cmd_addr, 0);
    chk({tag, "_wdata"}, cmd_if.cmd_wdata, 0);
    chk({tag, "_eop"}, err_opcode_tick, 0);
    chk({tag, "_eto"}, err_timeout_tick, 0);
    chk({tag, "_ovr"}, overrun_tick, 0);
  endtask

  initial begin
    logic [7:0] b;
    int hold, op, gap;
    cmd_if.cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    do_frame(1, 8'h01, 8'h23, 8'h45, 8'hA5, 0, -1, 8'h00, -1, 0);
    chk_counts("wr");

    do_frame(0, 8'h07, 8'hFF, 8'hFF, 8'h00, 20, -1, 8'h00, -1, 0);
    chk_counts("rd_bp");

    drive(1'b1, 8'h41, 1'b0);
    e_op++;
    @(negedge clk);
    chk("op_pulse", err_opcode_tick, 1);
    do_frame(0, 8'h00, 8'h12, 8'h34, 8'h00, 2, -1, 8'h00, -1, 1);
    chk_counts("badop");

    drive(1'b1, 8'h57, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    repeat (TT - 1) drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("to_early", n_to, e_to);
    drive(1'b0, 8'h00, 1'b1);
    e_to++;
    @(negedge clk);
    chk("to_pulse", err_timeout_tick, 1);
    drive(1'b0, 8'h00, 1'b0);
    do_frame(1, 8'h7A, 8'hBC, 8'hDE, 8'h3C, 1, -1, 8'h00, -1, 0);
    chk_counts("timeout");

    do_frame(1, 8'h00, 8'h11, 8'h22, 8'h5A, 0, -1, 8'h00, 1, 0);
    chk_counts("terminal");

    do_frame(1, 8'h05, 8'h66, 8'h77, 8'h99, 5, 2, 8'h52, -1, 0);
    do_frame(0, 8'h00, 8'h00, 8'h01, 8'h00, 3, 3, 8'h57, -1, 0);
    chk_counts("overrun");

    drive(1'b1, 8'h57, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk_zero("midrst");
    reset = 1'b0;
    do_frame(1, 8'h00, 8'h00, 8'h05, 8'h11, 0, -1, 8'h00, -1, 0);
    chk_counts("midrst");

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h52 || b == 8'h57) b = 8'h00;
        drive(1'b1, b, 1'b0);
        e_op++;
      end
      hold = $urandom_range(0, 6);
      op = ($urandom_range(0, 2) == 0) ? $urandom_range(0, hold) : -1;
      gap = $urandom_range(0, 4);
      do_frame(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), hold, op,
               8'($urandom_range(0, 255)), -1, gap);
      idle_gap($urandom_range(0, 3));
    end
    chk_counts("random");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
